// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and helpers for mem_req_bridge.
//   mem_typ_e     - core access size/sign encoding (X, B, H, W, BU, HU)
//   mem_fcn_e     - core access direction (M_XRD / M_XWR)
//   track_entry_t - per-request tracking record kept while the SRAM works
//   is_misaligned / store_strb / store_wdata / load_extract - datapath helpers
package mem_bridge_pkg;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5
    } mem_typ_e;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } mem_fcn_e;

    typedef struct packed {
        logic [1:0] off;
        mem_typ_e   typ;
        mem_fcn_e   fcn;
        logic       err;
    } track_entry_t;

    // Encodings 6/7 are not legal sizes and are always flagged.
    function automatic logic is_misaligned(input mem_typ_e typ, input logic [1:0] off);
        case (typ)
            MT_B, MT_BU: return 1'b0;
            MT_H, MT_HU: return off[0];
            MT_W, MT_X:  return off != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Halfwords only look at off[1], so an odd halfword address (reachable
    // only with misalignment detection disabled) lands on the containing half.
    function automatic logic [3:0] store_strb(input mem_typ_e typ, input logic [1:0] off);
        case (typ)
            MT_B, MT_BU: return 4'b0001 << off;
            MT_H, MT_HU: return 4'b0011 << {off[1], 1'b0};
            default:     return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input mem_typ_e typ, input logic [31:0] data);
        case (typ)
            MT_B, MT_BU: return {4{data[7:0]}};
            MT_H, MT_HU: return {2{data[15:0]}};
            default:     return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input mem_typ_e typ, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (typ)
            MT_B:    return {{24{b[7]}}, b};
            MT_BU:   return {24'h0, b};
            MT_H:    return {{16{h[15]}}, h};
            MT_HU:   return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_bridge_track_fifo.sv
// mem_bridge_track_fifo: DEPTH-entry FIFO of in-flight request records.
//   clk, rst   - clock, asynchronous active-low reset (flushes pointers/count)
//   push       - write push_entry at the tail (caller guarantees not full)
//   pop        - drop the head entry (caller guarantees not empty)
//   head       - current head entry (undefined while count == 0)
//   count      - number of valid entries, 0..DEPTH
module mem_bridge_track_fifo
    import mem_bridge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  track_entry_t             push_entry,
    output track_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    track_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count gates every read, so
    // flushing the pointers is enough and the array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: core byte-addressed request port -> word-addressed SRAM port.
// Issues loads/stores with byte strobes, tracks up to DEPTH outstanding SRAM
// requests and returns one registered response per request, in order, with
// sub-word loads extracted and sign/zero extended.
//   clk, rst         - clock, asynchronous active-low reset
//   req_*            - core request (valid/ready, addr, data, fcn, typ)
//   resp_*           - core response pulse (valid, data, err), no back-pressure
//   sram_req_*       - SRAM request (valid/ready, word addr, we, wdata, wstrb)
//   sram_resp_*      - SRAM in-order read/ack return
// Build option: define MEM_BRIDGE_MISALIGN_CHECK_EN to detect misaligned or
// illegal requests and answer them locally with resp_err=1; otherwise every
// request goes to the SRAM and resp_err stays 0.
module mem_req_bridge
    import mem_bridge_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic        req_fcn,
    input  logic [2:0]  req_typ,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        sram_req_valid,
    input  logic        sram_req_ready,
    output logic [29:0] sram_req_addr,
    output logic        sram_req_we,
    output logic [31:0] sram_req_wdata,
    output logic [3:0]  sram_req_wstrb,
    input  logic        sram_resp_valid,
    input  logic [31:0] sram_resp_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;

    mem_typ_e     typ;
    logic [1:0]   off;
    logic         mis;
    logic         not_full;
    logic         idle;
    logic         accept;
    logic         pop;
    logic [CW-1:0] count;
    track_entry_t push_entry;
    track_entry_t head;

    assign typ = mem_typ_e'(req_typ);
    assign off = req_addr[1:0];

`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
    assign mis = is_misaligned(typ, off);
`else
    assign mis = 1'b0;
`endif

    // No full-bypass: a retiring head does not free a slot in the same cycle.
    assign not_full = count < CW'(DEPTH);
    assign idle     = count == '0;

    // Gated with rst so the handshake outputs read low while reset is held.
    assign sram_req_valid = rst && req_valid && not_full && !mis;
    assign req_ready      = rst && req_valid &&
                            (mis ? idle : (not_full && sram_req_ready));
    assign accept         = req_valid && req_ready;

    assign sram_req_addr  = req_addr[31:2];
    assign sram_req_we    = req_fcn;
    assign sram_req_wdata = store_wdata(typ, req_data);
    assign sram_req_wstrb = store_strb(typ, off);

    assign push_entry = '{off: off, typ: typ, fcn: mem_fcn_e'(req_fcn), err: mis};

    // An error entry was answered at accept time and is simply discarded one
    // cycle later; an SRAM return is only consumed when something is tracked.
    assign pop = !idle && (head.err || sram_resp_valid);

    mem_bridge_track_fifo #(.DEPTH(DEPTH)) u_track (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    // Error accepts (only possible with count == 0) and SRAM returns (only
    // with count != 0) are mutually exclusive, so one priority chain suffices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else if (accept && mis) begin
            resp_valid <= 1'b1;
            resp_data  <= '0;
            resp_err   <= 1'b1;
        end else if (pop && !head.err) begin
            resp_valid <= 1'b1;
            resp_data  <= (head.fcn == M_XWR) ? '0
                          : load_extract(head.typ, head.off, sram_resp_rdata);
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_req_bridge.sv
module tb_mem_req_bridge;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic        req_fcn = 1'b0;
    logic [2:0]  req_typ = 3'd0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        sram_req_valid;
    logic        sram_req_ready = 1'b1;
    logic [29:0] sram_req_addr;
    logic        sram_req_we;
    logic [31:0] sram_req_wdata;
    logic [3:0]  sram_req_wstrb;
    logic        sram_resp_valid = 1'b0;
    logic [31:0] sram_resp_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_bridge #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_fcn         (req_fcn),
        .req_typ         (req_typ),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .sram_req_valid  (sram_req_valid),
        .sram_req_ready  (sram_req_ready),
        .sram_req_addr   (sram_req_addr),
        .sram_req_we     (sram_req_we),
        .sram_req_wdata  (sram_req_wdata),
        .sram_req_wstrb  (sram_req_wstrb),
        .sram_resp_valid (sram_resp_valid),
        .sram_resp_rdata (sram_resp_rdata)
    );

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d,
                             input logic f, input logic [2:0] t);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_fcn   = f;
        req_typ   = t;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_fcn   = 1'b0;
        req_typ   = 3'd0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sram_req_ready = 1'b1;
        drive_req(32'h100, 32'h0, 1'b0, 3'd3);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b exp 0", req_ready); end
        checks++; if (sram_req_valid !== 1'b0) begin errors++; $display("FAIL rst_sram_req_valid got %0b exp 0", sram_req_valid); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0b exp 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data got %h exp 0", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %0b exp 0", resp_err); end
        drop_req();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw();
        drive_req(32'h100, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (sram_req_valid !== 1'b1) begin errors++; $display("FAIL lw_sram_valid got %0b exp 1", sram_req_valid); end
        checks++; if (sram_req_addr !== 30'h40) begin errors++; $display("FAIL lw_sram_addr got %h exp 40", sram_req_addr); end
        checks++; if (sram_req_we !== 1'b0) begin errors++; $display("FAIL lw_sram_we got %0b exp 0", sram_req_we); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_req_ready got %0b exp 1", req_ready); end
        @(negedge clk);
        drop_req();
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_early got %0b exp 0", resp_valid); end
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lw_resp_valid got %0b exp 1", resp_valid); end
        checks++; if (resp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_resp_data got %h exp deadbeef", resp_data); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL lw_resp_err got %0b exp 0", resp_err); end
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL lw_resp_pulse got %0b exp 0", resp_valid); end
    endtask

    task automatic test_sub_word_loads();
        logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
        logic [2:0]  typs  [5] = '{3'd1, 3'd4, 3'd2, 3'd5, 3'd1};
        logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_req(addrs[i], 32'h0, 1'b0, typs[i]);
            #1;
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL sub_ready[%0d] got %0b exp 1", i, req_ready); end
            @(negedge clk);
            drop_req();
            sram_resp_valid = 1'b1;
            sram_resp_rdata = 32'h80FF0000;
            @(negedge clk);
            sram_resp_valid = 1'b0;
            #1;
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sub_valid[%0d] got %0b exp 1", i, resp_valid); end
            checks++; if (resp_data !== exps[i]) begin errors++; $display("FAIL sub_data[%0d] got %h exp %h", i, resp_data, exps[i]); end
        end
    endtask

    task automatic test_stores();
        logic [31:0] addrs [4] = '{32'h202, 32'h201, 32'h204, 32'h203};
        logic [31:0] datas [4] = '{32'h1234ABCD, 32'h000000A5, 32'hCAFEF00D, 32'h00000077};
        logic [2:0]  typs  [4] = '{3'd2, 3'd1, 3'd3, 3'd4};
        logic [31:0] wdats [4] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'hCAFEF00D, 32'h77777777};
        logic [3:0]  strbs [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        logic [29:0] waddr [4] = '{30'h80, 30'h80, 30'h81, 30'h80};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(addrs[i], datas[i], 1'b1, typs[i]);
            #1;
            checks++; if (sram_req_we !== 1'b1) begin errors++; $display("FAIL st_we[%0d] got %0b exp 1", i, sram_req_we); end
            checks++; if (sram_req_wdata !== wdats[i]) begin errors++; $display("FAIL st_wdata[%0d] got %h exp %h", i, sram_req_wdata, wdats[i]); end
            checks++; if (sram_req_wstrb !== strbs[i]) begin errors++; $display("FAIL st_wstrb[%0d] got %b exp %b", i, sram_req_wstrb, strbs[i]); end
            checks++; if (sram_req_addr !== waddr[i]) begin errors++; $display("FAIL st_addr[%0d] got %h exp %h", i, sram_req_addr, waddr[i]); end
            @(negedge clk);
            drop_req();
            sram_resp_valid = 1'b1;
            sram_resp_rdata = 32'hFFFFFFFF;
            @(negedge clk);
            sram_resp_valid = 1'b0;
            #1;
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL st_resp_valid[%0d] got %0b exp 1", i, resp_valid); end
            checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL st_resp_data[%0d] got %h exp 0", i, resp_data); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_req(32'h300, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a got %0b exp 1", req_ready); end
        @(negedge clk);
        drive_req(32'h304, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b got %0b exp 1", req_ready); end
        @(negedge clk);
        drive_req(32'h308, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %0b exp 0", req_ready); end
        checks++; if (sram_req_valid !== 1'b0) begin errors++; $display("FAIL b2b_full_sram_valid got %0b exp 0", sram_req_valid); end
        @(negedge clk);
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'h000000A0;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass got %0b exp 0", req_ready); end
        @(negedge clk);
        sram_resp_rdata = 32'h000000B0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hA0) begin errors++; $display("FAIL b2b_resp_a got %0b/%h exp 1/a0", resp_valid, resp_data); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c got %0b exp 1", req_ready); end
        @(negedge clk);
        drop_req();
        sram_resp_rdata = 32'h000000C0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hB0) begin errors++; $display("FAIL b2b_resp_b got %0b/%h exp 1/b0", resp_valid, resp_data); end
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hC0) begin errors++; $display("FAIL b2b_resp_c got %0b/%h exp 1/c0", resp_valid, resp_data); end
        @(negedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b exp 0", resp_valid); end
    endtask

`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
    task automatic test_misalign();
        logic [31:0] addrs [3] = '{32'h101, 32'h203, 32'h100};
        logic [2:0]  typs  [3] = '{3'd3, 3'd2, 3'd6};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_req(addrs[i], 32'h0, 1'b0, typs[i]);
            #1;
            checks++; if (sram_req_valid !== 1'b0) begin errors++; $display("FAIL mis_sram_valid[%0d] got %0b exp 0", i, sram_req_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_ready[%0d] got %0b exp 1", i, req_ready); end
            @(negedge clk);
            drop_req();
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 32'h0) begin
                errors++; $display("FAIL mis_resp[%0d] got v%0b e%0b d%h exp v1 e1 d0", i, resp_valid, resp_err, resp_data);
            end
            @(negedge clk);
            #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse[%0d] got %0b exp 0", i, resp_valid); end
        end
        // Misaligned request behind an outstanding load waits for the drain.
        drive_req(32'h400, 32'h0, 1'b0, 3'd3);
        @(negedge clk);
        drive_req(32'h101, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mis_busy_ready got %0b exp 0", req_ready); end
        @(negedge clk);
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'h00000011;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mis_busy_ready2 got %0b exp 0", req_ready); end
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h11 || resp_err !== 1'b0) begin
            errors++; $display("FAIL mis_busy_load got v%0b e%0b d%h exp v1 e0 d11", resp_valid, resp_err, resp_data);
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mis_drained_ready got %0b exp 1", req_ready); end
        @(negedge clk);
        drop_req();
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL mis_late_resp got v%0b e%0b exp v1 e1", resp_valid, resp_err); end
        @(negedge clk);
    endtask
`else
    task automatic test_no_misalign_check();
        @(negedge clk);
        drive_req(32'h101, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (sram_req_valid !== 1'b1) begin errors++; $display("FAIL nochk_sram_valid got %0b exp 1", sram_req_valid); end
        checks++; if (sram_req_addr !== 30'h40) begin errors++; $display("FAIL nochk_addr got %h exp 40", sram_req_addr); end
        @(negedge clk);
        drop_req();
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'h12345678;
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 32'h12345678) begin
            errors++; $display("FAIL nochk_resp got v%0b e%0b d%h exp v1 e0 d12345678", resp_valid, resp_err, resp_data);
        end
        drive_req(32'h203, 32'h0000BEEF, 1'b1, 3'd2);
        #1;
        checks++; if (sram_req_wstrb !== 4'b1100 || sram_req_wdata !== 32'hBEEFBEEF) begin
            errors++; $display("FAIL nochk_sh got %b/%h exp 1100/beefbeef", sram_req_wstrb, sram_req_wdata);
        end
        @(negedge clk);
        drop_req();
        sram_resp_valid = 1'b1;
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL nochk_sh_resp got v%0b e%0b exp v1 e0", resp_valid, resp_err); end
    endtask
`endif

    task automatic test_reset_midop();
        @(negedge clk);
        drive_req(32'h500, 32'h0, 1'b0, 3'd3);
        @(negedge clk);
        drive_req(32'h504, 32'h0, 1'b0, 3'd3);
        @(negedge clk);
        drop_req();
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'h0000005A;
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h5A) begin errors++; $display("FAIL mid_pre_resp got %0b/%h exp 1/5a", resp_valid, resp_data); end
        drive_req(32'h508, 32'h0, 1'b0, 3'd3);
        rst = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("FAIL mid_rst_resp got %0b/%h exp 0/0", resp_valid, resp_data); end
        checks++; if (req_ready !== 1'b0 || sram_req_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_hs got %0b/%0b exp 0/0", req_ready, sram_req_valid); end
        @(negedge clk);
        rst = 1'b1;
        drop_req();
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'h0000005B;
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_late_drop got %0b exp 0", resp_valid); end
        drive_req(32'h600, 32'h0, 1'b0, 3'd3);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready got %0b exp 1", req_ready); end
        @(negedge clk);
        drop_req();
        sram_resp_valid = 1'b1;
        sram_resp_rdata = 32'h00000066;
        @(negedge clk);
        sram_resp_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'h66) begin errors++; $display("FAIL mid_after_resp got %0b/%h exp 1/66", resp_valid, resp_data); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sub_word_loads();
        test_stores();
        test_back_to_back();
`ifdef MEM_BRIDGE_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_no_misalign_check();
`endif
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_req_bridge.md
# mem_req_bridge

- Converts the core's byte-addressed memory requests (addr/data/fcn/typ) into a word-addressed SRAM port with byte strobes.
- Returns exactly one response per request, in order, with sub-word loads extracted and sign- or zero-extended.
- Sits directly downstream of the core's imem/dmem request port and drives its response port; one instance per port.
- Tracks up to DEPTH outstanding requests so a pipelined SRAM can be kept busy.

## Interface
- DEPTH, 2: maximum outstanding SRAM requests (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  byte address
- req_data  in  32  store data (LSB-aligned)
- req_fcn  in  1  0=read (M_XRD), 1=write (M_XWR)
- req_typ  in  3  0=X, 1=B, 2=H, 3=W, 4=BU, 5=HU
- resp_valid  out  1  one-cycle response pulse (no back-pressure)
- resp_data  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned/illegal request, qualified by resp_valid
- sram_req_valid  out  1
- sram_req_ready  in  1
- sram_req_addr  out  30  req_addr[31:2]
- sram_req_we  out  1
- sram_req_wdata  out  32
- sram_req_wstrb  out  4
- sram_resp_valid  in  1  in-order, one per issued request, ≥1 cycle after issue
- sram_resp_rdata  in  32

## Operation
- Tracking FIFO, DEPTH entries: {off[1:0], typ, fcn, err}. Pushed on every accepted request.
- Normal request:
  - sram_req_valid = req_valid && count<DEPTH && !mis (combinational).
  - req_ready = same condition && sram_req_ready.
- Misaligned request (mis): H/HU with off[0]=1, W/X with off≠0, typ 6/7.
  - Accepted only when count==0; never issued to SRAM.
  - Retires the cycle after acceptance with resp_err=1, resp_data=0.
- No full-bypass: while count==DEPTH, req_ready=0 even if the head retires the same cycle.
- Stores:
  - B/BU: wdata={4{data[7:0]}}, wstrb=4'b0001<<off.
  - H/HU: wdata={2{data[15:0]}}, wstrb=4'b0011<<off.
  - W/X: wdata=data, wstrb=4'hF.
- Loads (on sram_resp_valid, head entry):
  - B: sext(rdata[8*off+:8]); BU: zext of the same byte.
  - H: sext(rdata[16*off[1]+:16]); HU: zext of the same halfword.
  - W/X: rdata.
- Stores complete on sram_resp_valid with resp_data=0.
- sram_resp_valid with count==0 is ignored; the FIFO does not underflow.
- Simultaneous push and pop: count unchanged, both pointers advance; pointers wrap modulo DEPTH.

## Timing
- Reset values: req_ready=0 (DEPTH>0, but outputs forced low during reset), resp_valid=0, resp_data=0, resp_err=0, sram_req_valid=0, count=0, pointers=0.
- Response outputs are registered: resp_valid rises the cycle after sram_resp_valid, or the cycle after an error accept.
- Minimum load latency: accept at T, SRAM responds at T+1, resp_valid at T+2.
- Throughput: one request and one response per cycle sustained with DEPTH≥2.
- Reset asserted mid-operation:
  - FIFO flushed, registered outputs cleared immediately.
  - SRAM responses arriving after reset release with count==0 are dropped.

## Configuration
- MEM_BRIDGE_MISALIGN_CHECK_EN defined: misalignment detection and error responses as above.
- Undefined:
  - No detection; resp_err is tied 0.
  - typ 6/7 treated as W.
  - Misaligned H uses off[1] only; misaligned W/X uses the word address ignoring off.
  - All requests go to SRAM.

## Structure
- Package mem_bridge_pkg:
  - mem_typ_e / mem_fcn_e enums with the encodings above.
  - Tracking-entry struct.
  - Store-strobe and load-extract functions.
- Sub-module mem_bridge_track_fifo: parameterised DEPTH, push/pop/count/head, async active-low reset.

## Test plan
- LW addr 0x100, SRAM rdata 0xDEADBEEF at T+1 -> sram_req_addr=0x40; resp_valid at T+2, resp_data=0xDEADBEEF, resp_err=0.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF_0000 -> resp_data 0xFFFFFF80, then 0x00000080.
- SH addr 0x202, data 0x1234ABCD -> wdata 0xABCDABCD, wstrb 4'b1100, we=1; resp_data=0.
- SRAM holds sram_resp_valid low, DEPTH=2, three back-to-back loads -> first two issued, third stalled (req_ready=0). Release -> three in-order responses.
- With macro, LW addr 0x101 while idle -> no SRAM request; next cycle resp_valid=1, resp_err=1. The same request with count=1 -> req_ready=0 until the FIFO drains.
- Reset asserted with two outstanding loads -> resp_valid=0 immediately; late sram_resp_valid after release produces no response.
